// File: rtl/key256_rev.sv
// ---------------------------------------------------------------------------
// key256_rev
// Round-key store and reverse sequencer for the AES-256 inverse cipher.
// A load starts the external 256-bit key expander and captures the NR+1
// forward round keys it emits, strictly in order. Once the whole set is held,
// each dec_start replays the keys from round NR down to round 0 over a
// valid/ready handshake, one key per cycle. The keys stay stored, so later
// decryptions with the same cipher key do not re-run the expansion.
//
// Ports
//   mclk, srst        clock; synchronous active-high reset
//   ck256_master      cipher key, sampled on load
//   load              request a new key expansion (pulse)
//   exp_start         one-cycle start pulse to the expander
//   exp_ck256         registered cipher key driven to the expander
//   rk_in*            round key, round index and valid strobe from expander
//   exp_busy          expander busy; a drop before the last key is an error
//   dec_start         begin one reverse key sequence
//   rk_dec*           round key, index, valid and ready toward the decryptor
//   keys_valid        a complete key set is stored
//   key_err           sticky: out-of-order capture or premature expander stop
// ---------------------------------------------------------------------------
module key256_rev #(
    parameter int NR = 14,
    parameter int KW = 128
) (
    input  logic          mclk,
    input  logic          srst,
    input  logic [0:255]  ck256_master,
    input  logic          load,
    output logic          exp_start,
    output logic [0:255]  exp_ck256,
    input  logic [0:KW-1] rk_in,
    input  logic [3:0]    rk_in_count,
    input  logic          rk_in_le,
    input  logic          exp_busy,
    input  logic          dec_start,
    output logic [0:KW-1] rk_dec,
    output logic [3:0]    rk_dec_count,
    output logic          rk_dec_vld,
    input  logic          rk_dec_rdy,
    output logic          keys_valid,
    output logic          key_err
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_FILL,
        ST_READY,
        ST_READ
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    fill_ptr;
    logic          exp_busy_q;
    logic [0:KW-1] key_mem [0:NR];

    // Decoded events for the current cycle
    logic start_load;
    logic start_read;
    logic cap_hit;
    logic cap_bad;
    logic cap_last;
    logic busy_fall;
    logic fill_abort;
    logic rd_xfer;
    logic rd_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: every clocked assignment is non-blocking so all registers see
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge mclk) begin
        if (srst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: defaulting to the current state first keeps this block free of
    // inferred latches when a branch leaves the state untouched.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (load) state_nxt = ST_START;
            ST_START: state_nxt = ST_FILL;
            ST_FILL: begin
                if (fill_abort)    state_nxt = ST_IDLE;
                else if (cap_last) state_nxt = ST_READY;
            end
            ST_READY: begin
                if (load)           state_nxt = ST_START;
                else if (dec_start) state_nxt = ST_READ;
            end
            ST_READ:  if (rd_done) state_nxt = ST_READY;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / event decode
    // ------------------------------------------------------------------
    always_comb begin
        start_load = load && (state == ST_IDLE || state == ST_READY);
        start_read = (state == ST_READY) && !load && dec_start;
        cap_hit    = (state == ST_FILL) && rk_in_le && (rk_in_count == fill_ptr);
        cap_bad    = (state == ST_FILL) && rk_in_le && (rk_in_count != fill_ptr);
        cap_last   = cap_hit && (fill_ptr == LAST);
        // A busy drop on the very cycle the last key arrives is a clean finish.
        busy_fall  = (state == ST_FILL) && exp_busy_q && !exp_busy && !cap_last;
        fill_abort = cap_bad || busy_fall;
        rd_xfer    = (state == ST_READ) && rk_dec_vld && rk_dec_rdy;
        rd_done    = rd_xfer && (rk_dec_count == 4'd0);
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (srst) begin
            exp_start    <= 1'b0;
            exp_ck256    <= '0;
            rk_dec       <= '0;
            rk_dec_count <= 4'd0;
            rk_dec_vld   <= 1'b0;
            keys_valid   <= 1'b0;
            key_err      <= 1'b0;
            fill_ptr     <= 4'd0;
            exp_busy_q   <= 1'b0;
        end else begin
            exp_busy_q <= exp_busy;
            exp_start  <= start_load;

            if (start_load) begin
                exp_ck256  <= ck256_master;
                fill_ptr   <= 4'd0;
                key_err    <= 1'b0;
                keys_valid <= 1'b0;
            end

            if (cap_hit)    fill_ptr   <= fill_ptr + 4'd1;
            if (cap_last)   keys_valid <= 1'b1;
            if (fill_abort) key_err    <= 1'b1;

            if (start_read) begin
                rk_dec       <= key_mem[NR];
                rk_dec_count <= LAST;
                rk_dec_vld   <= 1'b1;
            end else if (rd_xfer) begin
                if (rk_dec_count == 4'd0) begin
                    // Final key accepted; rk_dec keeps its last value.
                    rk_dec_vld <= 1'b0;
                end else begin
                    rk_dec       <= key_mem[rk_dec_count - 4'd1];
                    rk_dec_count <= rk_dec_count - 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-key storage
    // ------------------------------------------------------------------
    // NOTE: the key store has no reset; keys_valid alone decides whether
    // its contents may be used, so clearing it would only cost logic.
    always_ff @(posedge mclk) begin
        if (cap_hit) key_mem[fill_ptr] <= rk_in;
    end

endmodule
